hba_qenc_n: RTL and testbench

HBA_QENC_N -- requirements
Module: hba_qenc_n

---
 rtl/hba_qenc_n.sv | 186 ++++++++++++++++++
 tb/tb_hba_qenc_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hba_qenc_n.sv
// Multi-channel quadrature encoder counter on the HBA register bus.
// Each channel syncs A/B, decodes 4x steps, and keeps a counter plus a SNAP-captured copy.

module hba_qenc_n_ch #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic                   en,
  input  logic                   inv,
  input  logic                   snap,
  input  logic                   clr,
  output logic [COUNT_WIDTH-1:0] snap_val,
  output logic                   stepped,
  output logic                   illegal
);
  logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, snp_q, snp_d;
  logic fwd, rev;

  always_comb begin
    s1_d   = {enc_a, enc_b};
    s2_d   = s1_q;
    prev_d = s2_q;  // tracks even while disabled so enabling never produces a step
    fwd    = 1'b0;
    rev    = 1'b0;
    case ({prev_q, s2_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
      default: ;
    endcase
    illegal = en && ((prev_q ^ s2_q) == 2'b11);
    stepped = en && (fwd || rev) && !clr;
    cnt_d   = cnt_q;
    snp_d   = snp_q;
    if (snap) snp_d = cnt_q;
    if (stepped) cnt_d = (fwd ^ inv) ? cnt_q + COUNT_WIDTH'(1) : cnt_q - COUNT_WIDTH'(1);
    if (clr) begin
      cnt_d = '0;
      snp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      snp_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      snp_q  <= snp_d;
    end
  end

  assign snap_val = snp_q;
endmodule

module hba_qenc_n #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_CH            = 2,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  input  logic [NUM_CH-1:0]     quad_enc_a,
  input  logic [NUM_CH-1:0]     quad_enc_b
);
  localparam int BYTES = COUNT_WIDTH / 8;

  logic                  ack_q, ack_d;
  logic [DBUS_WIDTH-1:0] rdata_q, rdata_d, rd_val;
  logic                  gen_q, gen_d, ien_q, ien_d;
  logic [NUM_CH-1:0]     ch_en_q, ch_en_d, dir_inv_q, dir_inv_d, chg_q, chg_d, err_q, err_d;
  logic [NUM_CH-1:0]     stepped, illegal;
  logic [NUM_CH-1:0][COUNT_WIDTH-1:0] snap_val;
  logic [31:0]           off32;
  logic                  match, wr, snap_p, clr_p, w1c;
  logic [3:0]            chg4, err4;

  assign off32  = 32'(hba_abus[REG_ADDR_WIDTH-1:0]);
  assign match  = hba_select && !ack_q &&
                  (hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign wr     = match && !hba_rnw;
  assign snap_p = wr && (off32 == 32'd0) && hba_dbus[2];
  assign clr_p  = wr && (off32 == 32'd0) && hba_dbus[3];
  assign w1c    = wr && (off32 == 32'd3);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hba_qenc_n_ch #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
      .clk      (hba_clk),
      .rst_n    (hba_reset_n),
      .enc_a    (quad_enc_a[g]),
      .enc_b    (quad_enc_b[g]),
      .en       (gen_q && ch_en_q[g]),
      .inv      (dir_inv_q[g]),
      .snap     (snap_p),
      .clr      (clr_p),
      .snap_val (snap_val[g]),
      .stepped  (stepped[g]),
      .illegal  (illegal[g])
    );
  end

  always_comb begin
    chg4 = '0;
    err4 = '0;
    chg4[NUM_CH-1:0] = chg_q;
    err4[NUM_CH-1:0] = err_q;
    rd_val = '0;
    case (off32)
      32'd0: rd_val = DBUS_WIDTH'({ien_q, gen_q});
      32'd1: rd_val[NUM_CH-1:0] = ch_en_q;
      32'd2: rd_val[NUM_CH-1:0] = dir_inv_q;
      32'd3: rd_val = DBUS_WIDTH'({err4, chg4});
      default:
        for (int c = 0; c < NUM_CH; c++)
          for (int b = 0; b < BYTES; b++)
            if (off32 == 32'(4 + c*BYTES + b)) rd_val = DBUS_WIDTH'(snap_val[c][8*b +: 8]);
    endcase
  end

  always_comb begin
    ack_d     = match;
    rdata_d   = (match && hba_rnw) ? rd_val : '0;
    gen_d     = gen_q;
    ien_d     = ien_q;
    ch_en_d   = ch_en_q;
    dir_inv_d = dir_inv_q;
    if (wr && off32 == 32'd0) begin
      gen_d = hba_dbus[0];
      ien_d = hba_dbus[1];
    end
    if (wr && off32 == 32'd1) ch_en_d   = hba_dbus[NUM_CH-1:0];
    if (wr && off32 == 32'd2) dir_inv_d = hba_dbus[NUM_CH-1:0];
    // a fresh event wins over a write-1-to-clear in the same cycle
    chg_d = (chg_q & ~(w1c ? hba_dbus[NUM_CH-1:0] : '0)) | stepped;
    err_d = (err_q & ~(w1c ? hba_dbus[4 +: NUM_CH] : '0)) | illegal;
  end

  always_ff @(posedge hba_clk) begin
    if (!hba_reset_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      gen_q     <= 1'b0;
      ien_q     <= 1'b0;
      ch_en_q   <= '0;
      dir_inv_q <= '0;
      chg_q     <= '0;
      err_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      gen_q     <= gen_d;
      ien_q     <= ien_d;
      ch_en_q   <= ch_en_d;
      dir_inv_q <= dir_inv_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
    end
  end

  assign hba_dbus_slave    = rdata_q;
  assign hba_xferack_slave = ack_q;
  assign slave_interrupt   = ien_q && (|chg_q || |err_q);

  logic unused_dbus;
  assign unused_dbus = ^hba_dbus;
endmodule

// File: tb/tb_hba_qenc_n.sv
// Directed plus randomized checks of hba_qenc_n against a step-level behavioural model.

module tb_hba_qenc_n;
  logic        hba_clk = 1'b0;
  logic        hba_reset_n = 1'b0;
  logic        rnw = 1'b0, sel = 1'b0;
  logic [11:0] abus = '0;
  logic [7:0]  dbus = '0;
  logic [7:0]  dbus_slave;
  logic        ack, irq;
  logic [1:0]  enc_a = '0, enc_b = '0;

  int vecs = 0;
  int errs = 0;

  always #5 hba_clk = ~hba_clk;

  hba_qenc_n dut (
    .hba_clk           (hba_clk),
    .hba_reset_n       (hba_reset_n),
    .hba_rnw           (rnw),
    .hba_select        (sel),
    .hba_abus          (abus),
    .hba_dbus          (dbus),
    .hba_dbus_slave    (dbus_slave),
    .hba_xferack_slave (ack),
    .slave_interrupt   (irq),
    .quad_enc_a        (enc_a),
    .quad_enc_b        (enc_b)
  );

  // model: counters as plain integers, phase position as an index around the 4-state cycle
  int         m_cnt[2], m_snap[2];
  logic [1:0] m_prev[2];
  logic [1:0] m_en, m_inv, m_chg, m_err;
  logic       m_gen, m_ien;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      m_snap[c] = 0;
    end
    m_en = '0; m_inv = '0; m_chg = '0; m_err = '0; m_gen = 0; m_ien = 0;
  endtask

  task automatic m_step(input int ch, input logic [1:0] p, input bit discard);
    int d, s;
    d = (qidx(p) - qidx(m_prev[ch]) + 4) % 4;
    m_prev[ch] = p;
    if (m_gen && m_en[ch]) begin
      if (d == 2) m_err[ch] = 1'b1;
      else if (d != 0 && !discard) begin
        s = (d == 1) ? 1 : -1;
        if (m_inv[ch]) s = -s;
        m_cnt[ch] = (m_cnt[ch] + s) & 32'hFFFF;
        m_chg[ch] = 1'b1;
      end
    end
  endtask

  task automatic m_wr(input int off, input logic [7:0] d);
    case (off)
      0: begin
        m_gen = d[0];
        m_ien = d[1];
        if (d[3]) begin
          m_cnt[0] = 0; m_cnt[1] = 0; m_snap[0] = 0; m_snap[1] = 0;
        end else if (d[2]) begin
          m_snap[0] = m_cnt[0]; m_snap[1] = m_cnt[1];
        end
      end
      1: m_en  = d[1:0];
      2: m_inv = d[1:0];
      3: begin
        m_chg = m_chg & ~d[1:0];
        m_err = m_err & ~d[5:4];
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] exp_rd(input int off);
    int c, b;
    case (off)
      0: return {6'b0, m_ien, m_gen};
      1: return {6'b0, m_en};
      2: return {6'b0, m_inv};
      3: return {2'b0, m_err, 2'b0, m_chg};
      4, 5, 6, 7: begin
        c = (off - 4) / 2;
        b = (off - 4) % 2;
        return 8'((m_snap[c] >> (8*b)) & 255);
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic bus_wr(input int off, input logic [7:0] d);
    @(negedge hba_clk);
    sel = 1'b1; rnw = 1'b0; abus = 12'(off); dbus = d;
    @(negedge hba_clk);
    chk("wr_ack", ack, 1);
    sel = 1'b0;
    m_wr(off, d);
  endtask

  task automatic bus_rd(input int off, output logic [7:0] d);
    @(negedge hba_clk);
    sel = 1'b1; rnw = 1'b1; abus = 12'(off);
    @(negedge hba_clk);
    chk("rd_ack", ack, 1);
    d = dbus_slave;
    sel = 1'b0;
    @(negedge hba_clk);
    chk("ack_drop", ack, 0);
    chk("idle_data", dbus_slave, 0);
  endtask

  task automatic rd_chk(input string tag, input int off);
    logic [7:0] d;
    bus_rd(off, d);
    chk(tag, d, exp_rd(off));
  endtask

  task automatic set_enc(input int ch, input logic [1:0] p);
    @(negedge hba_clk);
    enc_a[ch] = p[1]; enc_b[ch] = p[0];
    m_step(ch, p, 1'b0);
    repeat (4) @(negedge hba_clk);
  endtask

  // input change lands on the counter on the same edge that commits the write
  task automatic enc_wr(input int ch, input logic [1:0] p, input int off, input logic [7:0] d);
    @(negedge hba_clk);
    enc_a[ch] = p[1]; enc_b[ch] = p[0];
    @(negedge hba_clk);
    @(negedge hba_clk);
    sel = 1'b1; rnw = 1'b0; abus = 12'(off); dbus = d;
    @(negedge hba_clk);
    chk("cw_ack", ack, 1);
    sel = 1'b0;
    m_wr(off, d);
    m_step(ch, p, (off == 0) && d[3]);
    repeat (3) @(negedge hba_clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] p;
    int op, ch, off;
    m_reset();
    m_prev[0] = 2'b00; m_prev[1] = 2'b00;

    repeat (3) @(negedge hba_clk);
    chk("rst_ack", ack, 0);
    chk("rst_data", dbus_slave, 0);
    chk("rst_irq", irq, 0);
    hba_reset_n = 1'b1;
    for (int o = 0; o < 8; o++) rd_chk("rst_reg", o);

    // forward count: 4 steps on ch0 then snapshot
    bus_wr(0, 8'h01);
    bus_wr(1, 8'h03);
    set_enc(0, 2'b10); set_enc(0, 2'b11); set_enc(0, 2'b01); set_enc(0, 2'b00);
    bus_wr(0, 8'h05);
    bus_rd(4, d); chk("fwd_b0", d, 8'h04);
    bus_rd(5, d); chk("fwd_b1", d, 8'h00);
    rd_chk("fwd_ch1b0", 6);
    rd_chk("fwd_ch1b1", 7);
    bus_rd(3, d); chk("fwd_status", d, 8'h01);
    rd_chk("ctrl_snap_rd0", 0);

    // wrap below zero, then inverted direction
    set_enc(1, 2'b01);
    bus_wr(0, 8'h05);
    bus_rd(6, d); chk("wrap_b0", d, 8'hFF);
    bus_rd(7, d); chk("wrap_b1", d, 8'hFF);
    bus_wr(2, 8'h02);
    set_enc(1, 2'b11);
    bus_wr(0, 8'h05);
    bus_rd(6, d); chk("inv_b0", d, 8'h00);
    bus_rd(7, d); chk("inv_b1", d, 8'h00);

    // illegal transition and interrupt
    bus_wr(3, 8'hFF);
    set_enc(0, 2'b11);
    bus_wr(0, 8'h03);
    bus_wr(0, 8'h07);
    rd_chk("ill_cnt", 4);
    bus_rd(3, d); chk("ill_status", d, 8'h10);
    chk("ill_irq", irq, 1);
    bus_wr(3, 8'h10);
    chk("ill_irq_clr", irq, 0);
    rd_chk("ill_status_clr", 3);

    // changed flag appears three edges after the input change
    @(negedge hba_clk);
    enc_a[0] = 1'b0; enc_b[0] = 1'b1;
    m_step(0, 2'b01, 1'b0);
    @(negedge hba_clk); chk("lat_e1", irq, 0);
    @(negedge hba_clk); chk("lat_e2", irq, 0);
    @(negedge hba_clk); chk("lat_e3", irq, 1);
    repeat (2) @(negedge hba_clk);
    bus_wr(3, 8'hFF);

    // step coinciding with SNAP, CLR and W1C
    enc_wr(0, 2'b00, 0, 8'h07);
    rd_chk("snap_pre", 4);
    bus_wr(0, 8'h07);
    rd_chk("snap_post", 4);
    enc_wr(0, 2'b10, 0, 8'h0B);
    bus_wr(0, 8'h07);
    rd_chk("clr_cnt", 4);
    bus_wr(3, 8'hFF);
    enc_wr(0, 2'b11, 3, 8'h01);
    bus_rd(3, d); chk("w1c_race", d, 8'h01);

    // bus edge cases
    rd_chk("unmapped", 8'h7F);
    bus_wr(4, 8'h55);
    rd_chk("ro_write", 4);
    @(negedge hba_clk);
    sel = 1'b1; rnw = 1'b1; abus = 12'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge hba_clk); chk("other_slot", ack, 0);
    end
    sel = 1'b0;

    // randomized mix of steps, register writes and reads
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1: begin
          ch = $urandom_range(0, 1);
          p = 2'($urandom);
          set_enc(ch, p);
        end
        2: begin
          d = 8'($urandom) & 8'h0F;
          if ($urandom_range(0, 7) != 0) d[3] = 1'b0;
          bus_wr(0, d);
        end
        3: bus_wr($urandom_range(1, 2), 8'($urandom));
        4: bus_wr($urandom_range(3, 9), 8'($urandom));
        default: begin
          off = ($urandom_range(0, 9) == 9) ? 8'h7F : $urandom_range(0, 9);
          rd_chk("rand_rd", off);
        end
      endcase
      chk("rand_irq", irq, {31'b0, m_ien && (|m_chg || |m_err)});
    end

    // reset after activity clears everything; counting resumes cleanly
    bus_wr(0, 8'h03);
    bus_wr(1, 8'h03);
    set_enc(1, (m_prev[1] == 2'b00) ? 2'b10 : 2'b00);
    bus_wr(0, 8'h07);
    @(negedge hba_clk);
    hba_reset_n = 1'b0;
    sel = 1'b1; rnw = 1'b0; abus = 12'h000; dbus = 8'h07;
    @(negedge hba_clk);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_data", dbus_slave, 0);
    sel = 1'b0;
    hba_reset_n = 1'b1;
    m_reset();
    for (int o = 0; o < 8; o++) rd_chk("post_rst", o);
    chk("post_rst_irq", irq, 0);
    bus_wr(0, 8'h01);
    bus_wr(1, 8'h03);
    p = m_prev[0];
    set_enc(0, (p == 2'b00) ? 2'b10 : (p == 2'b10) ? 2'b11 : (p == 2'b11) ? 2'b01 : 2'b00);
    bus_wr(0, 8'h05);
    bus_rd(4, d); chk("rst_first_step", d, 8'h01);
    rd_chk("rst_status", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
